// File: rtl/fsm_ctrl.sv
// rtl/fsm_ctrl.sv - compute pipeline phase sequencer; optional auto-advance under FSM_AUTO_EN
module fsm_ctrl #(
    parameter int FSM_BITS = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                auto,
    input  logic                start,
    input  logic                man_reset,
    input  logic                flag_firstload_end,
    input  logic                flag_cpb0_end,
    input  logic                flag_cpb1_end,
    input  logic                flag_cpb2_end,
    input  logic                flag_cpbldnew_end,
    input  logic                flag_cpb3_end,
    input  logic                flag_cpb4_end,
    output logic                busy,
    output logic [FSM_BITS-1:0] out_current_state,
    output logic [FSM_BITS-1:0] out_prev_state
);

    typedef enum logic [FSM_BITS-1:0] {
        S_IDLE        = FSM_BITS'(0),
        S_FIRST_LOAD  = FSM_BITS'(1),
        S_CPB_0       = FSM_BITS'(2),
        S_CPB_1       = FSM_BITS'(3),
        S_CPB_2       = FSM_BITS'(4),
        S_CPB_LOADNEW = FSM_BITS'(5),
        S_CPB_3       = FSM_BITS'(6),
        S_CPB_4       = FSM_BITS'(7)
    } state_t;

    state_t                r_state;
    logic   [FSM_BITS-1:0] r_prev;
    logic                  r_done;

    state_t                w_next;
    logic                  w_flag_cur;
    logic                  w_done_eff;
    logic                  w_auto;
    logic                  w_go;
    logic                  w_adv;
    logic                  w_change;

`ifdef FSM_AUTO_EN
    assign w_auto = auto;
`else
    // Port kept so the interface is identical in both builds.
    logic w_auto_unused;
    assign w_auto_unused = auto;
    assign w_auto        = 1'b0;
`endif

    // Select the end flag belonging to the current phase; other flags are ignored.
    always_comb begin
        w_flag_cur = 1'b0;
        case (r_state)
            S_FIRST_LOAD:  w_flag_cur = flag_firstload_end;
            S_CPB_0:       w_flag_cur = flag_cpb0_end;
            S_CPB_1:       w_flag_cur = flag_cpb1_end;
            S_CPB_2:       w_flag_cur = flag_cpb2_end;
            S_CPB_LOADNEW: w_flag_cur = flag_cpbldnew_end;
            S_CPB_3:       w_flag_cur = flag_cpb3_end;
            S_CPB_4:       w_flag_cur = flag_cpb4_end;
            default:       w_flag_cur = 1'b0;
        endcase
    end

    // A flag seen in this very cycle counts as done, so a one-cycle pulse is enough.
    assign w_done_eff = r_done | w_flag_cur;
    assign w_go       = start | w_auto;
    assign w_adv      = w_done_eff & w_go;

    // Next-state logic: manual reset wins, illegal codes fall back to IDLE.
    always_comb begin
        w_next = r_state;
        if (man_reset) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:        if (w_go)  w_next = S_FIRST_LOAD;
                S_FIRST_LOAD:  if (w_adv) w_next = S_CPB_0;
                S_CPB_0:       if (w_adv) w_next = S_CPB_1;
                S_CPB_1:       if (w_adv) w_next = S_CPB_2;
                S_CPB_2:       if (w_adv) w_next = S_CPB_LOADNEW;
                S_CPB_LOADNEW: if (w_adv) w_next = S_CPB_3;
                S_CPB_3:       if (w_adv) w_next = S_CPB_4;
                S_CPB_4:       if (w_adv) w_next = S_CPB_0;
                default:       w_next = S_IDLE;
            endcase
        end
    end

    assign w_change = (w_next != r_state);

    // State register; previous state only moves when the state actually changes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_prev  <= '0;
        end else begin
            r_state <= w_next;
            if (w_change) begin
                r_prev <= r_state;
            end
        end
    end

    // Sticky done bit: cleared on any transition or manual reset so it never leaks into the next phase.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_done <= 1'b0;
        end else if (man_reset || w_change) begin
            r_done <= 1'b0;
        end else if (w_flag_cur) begin
            r_done <= 1'b1;
        end
    end

    assign busy              = (r_state != S_IDLE) && !w_done_eff;
    assign out_current_state = r_state;
    assign out_prev_state    = r_prev;

endmodule

// File: tb/tb_fsm_ctrl.sv
// tb/tb_fsm_ctrl.sv - table-driven scoreboard bench for fsm_ctrl
module tb_fsm_ctrl;

    localparam int FSM_BITS = 5;

    localparam logic [6:0] F_NONE = 7'b0000000;
    localparam logic [6:0] F_FL   = 7'b1000000;
    localparam logic [6:0] F_C0   = 7'b0100000;
    localparam logic [6:0] F_C1   = 7'b0010000;
    localparam logic [6:0] F_C2   = 7'b0001000;
    localparam logic [6:0] F_LN   = 7'b0000100;
    localparam logic [6:0] F_C3   = 7'b0000010;
    localparam logic [6:0] F_C4   = 7'b0000001;

    logic                clk;
    logic                reset;
    logic                auto;
    logic                start;
    logic                man_reset;
    logic [6:0]          flags;
    logic                busy;
    logic [FSM_BITS-1:0] out_current_state;
    logic [FSM_BITS-1:0] out_prev_state;

    int n_checks;
    int n_fail;

    typedef struct {
        logic       start;
        logic       auto;
        logic       man_reset;
        logic [6:0] flags;
        int         exp_state;
        int         exp_prev;
        logic       exp_busy;
    } vec_t;

    vec_t tab_a[$];
    vec_t tab_b[$];
    vec_t sb[$];

    fsm_ctrl #(.FSM_BITS(FSM_BITS)) dut (
        .clk                (clk),
        .reset              (reset),
        .auto               (auto),
        .start              (start),
        .man_reset          (man_reset),
        .flag_firstload_end (flags[6]),
        .flag_cpb0_end      (flags[5]),
        .flag_cpb1_end      (flags[4]),
        .flag_cpb2_end      (flags[3]),
        .flag_cpbldnew_end  (flags[2]),
        .flag_cpb3_end      (flags[1]),
        .flag_cpb4_end      (flags[0]),
        .busy               (busy),
        .out_current_state  (out_current_state),
        .out_prev_state     (out_prev_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic s, input logic a, input logic m, input logic [6:0] f,
                                input int es, input int ep, input logic eb);
        vec_t v;
        v.start = s; v.auto = a; v.man_reset = m; v.flags = f;
        v.exp_state = es; v.exp_prev = ep; v.exp_busy = eb;
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Drive one cycle of stimulus, push its expectation, then pop and compare after the edge.
    task automatic apply(input vec_t v, input string tag, input int idx);
        vec_t e;
        @(negedge clk);
        start = v.start; auto = v.auto; man_reset = v.man_reset; flags = v.flags;
        sb.push_back(v);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check($sformatf("%s[%0d].state", tag, idx), int'(out_current_state), e.exp_state);
        check($sformatf("%s[%0d].prev", tag, idx),  int'(out_prev_state),    e.exp_prev);
        check($sformatf("%s[%0d].busy", tag, idx),  int'(busy),              int'(e.exp_busy));
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset = 1'b1; auto = 1'b0; start = 1'b0; man_reset = 1'b0; flags = F_NONE;

        // start, FIRST_LOAD flag pulse, 3 idle cycles, start; then CPB_0; CPB_1 held start w/o flag
        tab_a.push_back(mk(1, 0, 0, F_NONE, 1, 0, 1));
        tab_a.push_back(mk(0, 0, 0, F_NONE, 1, 0, 1));
        tab_a.push_back(mk(0, 0, 0, F_FL,   1, 0, 0));
        tab_a.push_back(mk(0, 0, 0, F_NONE, 1, 0, 0));
        tab_a.push_back(mk(0, 0, 0, F_NONE, 1, 0, 0));
        tab_a.push_back(mk(0, 0, 0, F_NONE, 1, 0, 0));
        tab_a.push_back(mk(1, 0, 0, F_NONE, 2, 1, 1));
        tab_a.push_back(mk(0, 0, 0, F_C0,   2, 1, 0));
        tab_a.push_back(mk(1, 0, 0, F_NONE, 3, 2, 1));
        tab_a.push_back(mk(1, 0, 0, F_NONE, 3, 2, 1));
        tab_a.push_back(mk(1, 0, 0, F_NONE, 3, 2, 1));
        tab_a.push_back(mk(1, 0, 0, F_C1,   4, 3, 1));

        // rest of ring back to CPB_0, same-cycle flag+start, walk to CPB_3, man_reset, restart
        tab_b.push_back(mk(0, 0, 0, F_LN,   5, 4, 0));
        tab_b.push_back(mk(1, 0, 0, F_NONE, 6, 5, 1));
        tab_b.push_back(mk(0, 0, 0, F_C3,   6, 5, 0));
        tab_b.push_back(mk(1, 0, 0, F_NONE, 7, 6, 1));
        tab_b.push_back(mk(0, 0, 0, F_C4,   7, 6, 0));
        tab_b.push_back(mk(1, 0, 0, F_NONE, 2, 7, 1));
        tab_b.push_back(mk(1, 0, 0, F_C0,   3, 2, 1));
        tab_b.push_back(mk(0, 0, 0, F_NONE, 3, 2, 1));
        tab_b.push_back(mk(1, 0, 0, F_C1,   4, 3, 1));
        tab_b.push_back(mk(1, 0, 0, F_C2,   5, 4, 1));
        tab_b.push_back(mk(1, 0, 0, F_LN,   6, 5, 1));
        tab_b.push_back(mk(1, 0, 1, F_NONE, 0, 6, 0));
        tab_b.push_back(mk(0, 0, 0, F_NONE, 0, 6, 0));
        tab_b.push_back(mk(1, 0, 0, F_NONE, 1, 0, 1));
        tab_b.push_back(mk(0, 0, 0, F_FL,   1, 0, 0));

        repeat (4) @(posedge clk);
        #1;
        check("reset.state", int'(out_current_state), 0);
        check("reset.prev",  int'(out_prev_state),    0);
        check("reset.busy",  int'(busy),              0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < tab_a.size(); i++) apply(tab_a[i], "tab_a", i);

        // auto-advance in CPB_2; both builds converge on CPB_LOADNEW with prev CPB_2
`ifdef FSM_AUTO_EN
        apply(mk(0, 1, 0, F_C2,   5, 4, 1), "auto", 0);
        apply(mk(0, 0, 0, F_NONE, 5, 4, 1), "auto", 1);
`else
        apply(mk(0, 1, 0, F_C2,   4, 3, 0), "auto", 0);
        apply(mk(0, 1, 0, F_NONE, 4, 3, 0), "auto", 1);
        apply(mk(1, 0, 0, F_NONE, 5, 4, 1), "auto", 2);
`endif

        for (int i = 0; i < tab_b.size(); i++) apply(tab_b[i], "tab_b", i);

        // asynchronous reset mid-phase clears everything without waiting for an edge
        @(negedge clk);
        flags = F_NONE;
        reset = 1'b1;
        #1;
        check("areset.state", int'(out_current_state), 0);
        check("areset.prev",  int'(out_prev_state),    0);
        check("areset.busy",  int'(busy),              0);
        @(negedge clk);
        reset = 1'b0;
        apply(mk(0, 0, 0, F_NONE, 0, 0, 0), "post", 0);
        apply(mk(1, 0, 0, F_NONE, 1, 0, 1), "post", 1);

        if (sb.size() != 0) check("scoreboard.leftover", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
